// File: rtl/arbiter_rr_nreq_if.sv
// Request/grant bundle for arbiter_rr_nreq.
// The slave modport is the arbiter side; the master modport is the requester/consumer side.
interface arbiter_rr_nreq_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic               i_en;
  logic [NUM_REQ-1:0] i_req_bus;
  logic               i_last;
  logic               i_ready;
  logic               o_valid;
  logic [NUM_REQ-1:0] o_grant_onehot;
  logic [IDX_W-1:0]   o_grant_idx;

  modport master (
    output i_en, i_req_bus, i_last, i_ready,
    input  o_valid, o_grant_onehot, o_grant_idx
  );

  modport slave (
    input  i_en, i_req_bus, i_last, i_ready,
    output o_valid, o_grant_onehot, o_grant_idx
  );
endinterface

// File: rtl/arbiter_rr_nreq.sv
// Round-robin arbiter for NUM_REQ requesters with a registered last-served pointer.
// The grant is combinational from the requests and the registered state.
// Optional packet lock: define ARBITER_PKT_LOCK_EN to hold the grant on one
// requester until a beat with i_last=1 is accepted.
module arbiter_rr_nreq #(
  parameter int NUM_REQ = 4
) (
  input logic              clk,
  input logic              rst_n,
  arbiter_rr_nreq_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  logic [IDX_W-1:0] last_ptr;
  logic [IDX_W-1:0] last_ptr_nxt;
  logic             run;
  logic             sel_found;
  logic [IDX_W-1:0] sel_idx;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  // Reset gates the outputs so nothing is offered while rst_n is low.
  assign run = rst_n & bus.i_en;

  // Rotating search from last_ptr+1 upward; the wrap is an explicit compare so
  // non-power-of-2 sizes never visit an out-of-range index.
  always_comb begin
    logic [IDX_W-1:0] cand;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = last_ptr;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
      if (!sel_found && bus.i_req_bus[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

`ifdef ARBITER_PKT_LOCK_EN
  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] lock_idx;
  logic [IDX_W-1:0] lock_idx_nxt;

  // Packet-lock state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  // Grant selection and next-state: free arbitration in IDLE, forced grant in LOCKED.
  always_comb begin
    state_nxt    = state;
    lock_idx_nxt = lock_idx;
    last_ptr_nxt = last_ptr;
    grant_valid  = 1'b0;
    grant_idx    = '0;
    case (state)
      ST_IDLE: begin
        grant_valid = run & sel_found;
        grant_idx   = sel_idx;
        if (grant_valid && bus.i_ready) begin
          last_ptr_nxt = sel_idx;
          if (!bus.i_last) begin
            state_nxt    = ST_LOCKED;
            lock_idx_nxt = sel_idx;
          end
        end
      end
      ST_LOCKED: begin
        grant_valid = run & bus.i_req_bus[lock_idx];
        grant_idx   = lock_idx;
        if (grant_valid && bus.i_ready && bus.i_last) begin
          state_nxt    = ST_IDLE;
          last_ptr_nxt = lock_idx;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end
`else
  logic unused_last;
  assign unused_last = bus.i_last;

  // Per-beat round robin: every accepted beat moves the pointer.
  always_comb begin
    grant_valid  = run & sel_found;
    grant_idx    = sel_idx;
    last_ptr_nxt = last_ptr;
    if (grant_valid && bus.i_ready) begin
      last_ptr_nxt = sel_idx;
    end
  end
`endif

  // Last-served pointer; reset value gives requester 0 top priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ptr <= LAST_IDX;
    end else begin
      last_ptr <= last_ptr_nxt;
    end
  end

  // Grant outputs, forced to zero when nothing is offered.
  always_comb begin
    bus.o_valid        = grant_valid;
    bus.o_grant_idx    = grant_valid ? grant_idx : '0;
    bus.o_grant_onehot = grant_valid ? (NUM_REQ'(1) << grant_idx) : '0;
  end
endmodule
